eeg_pea_disp: RTL and testbench
===============================

Name: eeg_pea_disp

Overview:
- Parametrised operand dispatcher for the EEG PE array; next-generation front-end of the PEA engine.
- Pairs per-column activation streams with per-PE weight streams and buffers each pair in a per-PE FIFO of configurable depth.
- Adds a global-broadcast mode, a per-PE enable mask, weight-last consistency checking, flush, and occupancy-based idle.
- Sits between the activation/weight fetch units and the PE instances.

Parameters:
- PE_ROW, 4, PE rows per column.
- PE_COL, 4, PE columns.
- DATA_ACT_DW, 8, activation data width.
- DATA_WEI_DW, 8, weight data width.
- ACT_IW, 12, activation info (address) width.
- WEI_IW, 3, weight info (index) width.
- BUF_DEPTH, 4, per-PE FIFO depth; power of two, >=2.
- BUF_AW, $clog2(BUF_DEPTH), FIFO pointer width (derived).

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, synchronous reset, active-high: asserted when 1, sampled on rising clk edge.
- CFG_MODE, in, 1, 0 = column broadcast, 1 = global broadcast of column-0 activation.
- CFG_PE_EN, in, PE_COL*PE_ROW, PE enable mask [c][r].
- FLUSH, in, 1, synchronous clear of all FIFOs and error flags.
- IS_IDLE, out, 1, all FIFOs empty.
- ERR_LST, out, PE_COL, sticky weight-last mismatch flag per column.
- ACT_VLD / ACT_RDY / ACT_LST, in/out/in, PE_COL each.
- ACT_DAT, in, PE_COL*DATA_ACT_DW.
- ACT_INF, in, PE_COL*ACT_IW.
- WEI_VLD / WEI_RDY / WEI_LST, in/out/in, PE_COL*PE_ROW each.
- WEI_DAT, in, PE_COL*PE_ROW*DATA_WEI_DW.
- WEI_INF, in, PE_COL*PE_ROW*WEI_IW.
- PE_VLD, out, PE_COL*PE_ROW, FIFO non-empty.
- PE_RDY, in, PE_COL*PE_ROW, PE accepts head entry.
- PE_DAT, out, PE_COL*PE_ROW*(DATA_ACT_DW+DATA_WEI_DW+ACT_IW+WEI_IW+2), head entry packed {wei_lst, act_lst, wei_inf, act_inf, wei_dat, act_dat}, act_dat at LSB.

Behaviour:
- Reset or FLUSH: all FIFO pointers and counters to 0, ERR_LST=0. Outputs then read PE_VLD=0, IS_IDLE=1, ACT_RDY=0, WEI_RDY=0; PE_DAT is don't-care while PE_VLD=0. Reset wins over every other event.
- Enabled set E_c = {r : CFG_PE_EN[c][r]}. Disabled PE: WEI_RDY=0, never pushed; its FIFO still drains normally.
- Mode 0, per column c:
  - src = ACT[c].
  - wok_c: WEI_VLD and !full hold for all r in E_c.
  - lok_c: the WEI_LST values across E_c are all equal.
  - fire_c = ACT_VLD[c] & wok_c & lok_c & (E_c non-empty).
- Mode 1:
  - src = ACT[0] for every column.
  - A single fire = ACT_VLD[0] & all wok_c & all lok_c, taken over every column with E_c non-empty. At least one PE must be enabled overall.
  - fire_c = fire for those columns; columns with empty E_c do not fire.
  - ACT_RDY[c>0]=0.
- On fire_c:
  - WEI_RDY[c][r]=1 for r in E_c.
  - Each of those FIFOs pushes {WEI_LST, src ACT_LST, WEI_INF, src ACT_INF, WEI_DAT, src ACT_DAT}.
  - The activation is held (ACT_RDY=0) until the beat where the common WEI_LST=1; that beat asserts ACT_RDY of the source column. One activation spans a whole weight group.
- Ready outputs are combinational from registered full flags and input valids; no combinational path from PE_RDY to WEI_RDY/ACT_RDY.
- Full FIFO blocks push even if it pops the same cycle (no full bypass). Push and pop in the same cycle on a non-full, non-empty FIFO leave the count unchanged.
- Pointers wrap modulo BUF_DEPTH. The count is BUF_AW+1 bits, full = (count==BUF_DEPTH).
- Latency: entry pushed at edge t gives PE_VLD=1 after t, with PE_DAT = head (show-ahead). Pop on PE_VLD & PE_RDY.
- ERR_LST[c]:
  - Set when ACT_VLD of the source is high, wok_c holds, and lok_c is false.
  - The column then stalls; it does not fire until the weights agree.
  - Cleared only by reset or FLUSH.
- CFG_MODE and CFG_PE_EN may change only while IS_IDLE=1 and no valid is asserted; otherwise behaviour is undefined.

Test Plan:
- Reset with all VLD=1 → PE_VLD=0, WEI_RDY=0, ACT_RDY=0, IS_IDLE=1. Release → first push visible one cycle later.
- Mode 0, 4x4 all enabled, ACT[1]=0x5A held while 3 weight beats (LST on 3rd) → each col-1 FIFO holds 3 entries with act_dat 0x5A; ACT_RDY[1]=1 only on beat 3.
- PE_RDY[2][0]=0, BUF_DEPTH=4, continuous stream → col 2 stalls after 4 pushes; WEI_RDY[2][*]=0; other columns keep flowing.
- Mode 1, ACT[0]=0x11 → all 16 FIFOs get act_dat 0x11; ACT_RDY[1..3] stay 0.
- CFG_PE_EN[3][2]=0 → WEI_RDY[3][2] stays 0, PE_VLD[3][2] stays 0, rest of col 3 proceeds. Rows 0/1 WEI_LST=1, row 3 WEI_LST=0 → ERR_LST[3]=1, no push, until FLUSH.
- FIFO full with PE_RDY=1 and new push offered → pop only that cycle, count 3; push accepted next cycle.

Source files
------------

// File: rtl/eeg_pea_disp.sv
// Operand dispatcher for the EEG PE array: pairs column activations with per-PE
// weights and buffers each pair in a show-ahead FIFO in front of every PE.
module eeg_pea_disp #(
  parameter int PE_ROW      = 4,
  parameter int PE_COL      = 4,
  parameter int DATA_ACT_DW = 8,
  parameter int DATA_WEI_DW = 8,
  parameter int ACT_IW      = 12,
  parameter int WEI_IW      = 3,
  parameter int BUF_DEPTH   = 4,
  parameter int BUF_AW      = $clog2(BUF_DEPTH)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  CFG_MODE,
  input  logic [PE_COL*PE_ROW-1:0]              CFG_PE_EN,
  input  logic                                  FLUSH,
  output logic                                  IS_IDLE,
  output logic [PE_COL-1:0]                     ERR_LST,
  input  logic [PE_COL-1:0]                     ACT_VLD,
  output logic [PE_COL-1:0]                     ACT_RDY,
  input  logic [PE_COL-1:0]                     ACT_LST,
  input  logic [PE_COL*DATA_ACT_DW-1:0]         ACT_DAT,
  input  logic [PE_COL*ACT_IW-1:0]              ACT_INF,
  input  logic [PE_COL*PE_ROW-1:0]              WEI_VLD,
  output logic [PE_COL*PE_ROW-1:0]              WEI_RDY,
  input  logic [PE_COL*PE_ROW-1:0]              WEI_LST,
  input  logic [PE_COL*PE_ROW*DATA_WEI_DW-1:0]  WEI_DAT,
  input  logic [PE_COL*PE_ROW*WEI_IW-1:0]       WEI_INF,
  output logic [PE_COL*PE_ROW-1:0]              PE_VLD,
  input  logic [PE_COL*PE_ROW-1:0]              PE_RDY,
  output logic [PE_COL*PE_ROW*(DATA_ACT_DW+DATA_WEI_DW+ACT_IW+WEI_IW+2)-1:0] PE_DAT
);

  localparam int NPE = PE_COL * PE_ROW;
  localparam int EW  = DATA_ACT_DW + DATA_WEI_DW + ACT_IW + WEI_IW + 2;
  localparam int CW  = BUF_AW + 1;

  logic                          w_clr;
  logic                          w_gfire;
  logic                          w_glst;
  logic [PE_COL-1:0]             w_en_any;
  logic [PE_COL-1:0]             w_wok;
  logic [PE_COL-1:0]             w_lok;
  logic [PE_COL-1:0]             w_lst;
  logic [PE_COL-1:0]             w_src_vld;
  logic [PE_COL-1:0]             w_src_lst;
  logic [PE_COL-1:0]             w_fire;
  logic [PE_COL-1:0]             w_err_set;
  logic [PE_COL*DATA_ACT_DW-1:0] w_src_dat;
  logic [PE_COL*ACT_IW-1:0]      w_src_inf;
  logic [NPE-1:0]                w_full;
  logic [NPE-1:0]                w_empty;
  logic [NPE-1:0]                w_pop;
  logic [PE_COL-1:0]             r_err;

  assign w_clr   = rst_n | FLUSH;
  // Global broadcast fires only when every populated column is ready and consistent.
  assign w_gfire = ~w_clr & ACT_VLD[0] & (|w_en_any) & (&(~w_en_any | (w_wok & w_lok)));
  assign w_glst  = &(~w_en_any | w_lst);

  assign IS_IDLE = &w_empty;
  assign ERR_LST = r_err;

  genvar gi;
  generate
    for (gi = 0; gi < PE_COL; gi++) begin : g_col
      logic [PE_ROW-1:0] w_en;
      logic [PE_ROW-1:0] w_wvld;
      logic [PE_ROW-1:0] w_wlst;
      logic [PE_ROW-1:0] w_wfull;

      assign w_en    = CFG_PE_EN[gi*PE_ROW +: PE_ROW];
      assign w_wvld  = WEI_VLD[gi*PE_ROW +: PE_ROW];
      assign w_wlst  = WEI_LST[gi*PE_ROW +: PE_ROW];
      assign w_wfull = w_full[gi*PE_ROW +: PE_ROW];

      assign w_en_any[gi] = |w_en;
      assign w_wok[gi]    = &(~w_en | (w_wvld & ~w_wfull));
      assign w_lst[gi]    = |(w_en & w_wlst);
      assign w_lok[gi]    = ~w_lst[gi] | (&(~w_en | w_wlst));

      assign w_src_vld[gi] = CFG_MODE ? ACT_VLD[0] : ACT_VLD[gi];
      assign w_src_lst[gi] = CFG_MODE ? ACT_LST[0] : ACT_LST[gi];
      assign w_src_dat[gi*DATA_ACT_DW +: DATA_ACT_DW] =
        CFG_MODE ? ACT_DAT[0 +: DATA_ACT_DW] : ACT_DAT[gi*DATA_ACT_DW +: DATA_ACT_DW];
      assign w_src_inf[gi*ACT_IW +: ACT_IW] =
        CFG_MODE ? ACT_INF[0 +: ACT_IW] : ACT_INF[gi*ACT_IW +: ACT_IW];

      assign w_fire[gi] = CFG_MODE ? (w_gfire & w_en_any[gi])
                                   : (~w_clr & ACT_VLD[gi] & w_wok[gi] & w_lok[gi] & w_en_any[gi]);
      assign w_err_set[gi] = w_src_vld[gi] & w_wok[gi] & ~w_lok[gi];
      assign WEI_RDY[gi*PE_ROW +: PE_ROW] = {PE_ROW{w_fire[gi]}} & w_en;

      // The activation is consumed only on the last beat of its weight group.
      if (gi == 0) begin : g_src
        assign ACT_RDY[gi] = CFG_MODE ? (w_gfire & w_glst) : (w_fire[gi] & w_lst[gi]);
      end else begin : g_nsrc
        assign ACT_RDY[gi] = ~CFG_MODE & w_fire[gi] & w_lst[gi];
      end
    end

    for (gi = 0; gi < NPE; gi++) begin : g_pe
      localparam int COL = gi / PE_ROW;
      logic [EW-1:0]     r_mem [BUF_DEPTH];
      logic [BUF_AW-1:0] r_wptr;
      logic [BUF_AW-1:0] r_rptr;
      logic [CW-1:0]     r_cnt;
      logic [EW-1:0]     w_entry;

      assign w_entry = {WEI_LST[gi], w_src_lst[COL],
                        WEI_INF[gi*WEI_IW +: WEI_IW], w_src_inf[COL*ACT_IW +: ACT_IW],
                        WEI_DAT[gi*DATA_WEI_DW +: DATA_WEI_DW],
                        w_src_dat[COL*DATA_ACT_DW +: DATA_ACT_DW]};

      assign w_full[gi]  = (r_cnt == CW'(BUF_DEPTH));
      assign w_empty[gi] = (r_cnt == '0);
      assign PE_VLD[gi]  = ~w_empty[gi];
      assign w_pop[gi]   = PE_VLD[gi] & PE_RDY[gi];
      assign PE_DAT[gi*EW +: EW] = r_mem[r_rptr];

      always_ff @(posedge clk) begin
        if (w_clr) begin
          r_wptr <= '0;
          r_rptr <= '0;
          r_cnt  <= '0;
        end else begin
          if (WEI_RDY[gi]) r_wptr <= r_wptr + BUF_AW'(1);
          if (w_pop[gi])   r_rptr <= r_rptr + BUF_AW'(1);
          r_cnt <= r_cnt + CW'(WEI_RDY[gi]) - CW'(w_pop[gi]);
        end
      end

      always_ff @(posedge clk) begin
        if (WEI_RDY[gi]) r_mem[r_wptr] <= w_entry;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_clr) r_err <= '0;
    else       r_err <= r_err | w_err_set;
  end

endmodule

// File: tb/tb_eeg_pea_disp.sv
// Randomized scoreboard bench for eeg_pea_disp: a queue-based reference model
// predicts readies and FIFO contents; a monitor checks every PE pop.
module tb_eeg_pea_disp;
  localparam int PE_ROW = 4, PE_COL = 4, ADW = 8, WDW = 8, AIW = 12, WIW = 3;
  localparam int DEPTH = 4, NPE = PE_ROW * PE_COL, EW = ADW + WDW + AIW + WIW + 2;

  typedef logic [EW-1:0] entry_t;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic                  CFG_MODE = 1'b0;
  logic [NPE-1:0]        CFG_PE_EN = '1;
  logic                  FLUSH = 1'b0;
  logic                  IS_IDLE;
  logic [PE_COL-1:0]     ERR_LST;
  logic [PE_COL-1:0]     ACT_VLD = '1;
  logic [PE_COL-1:0]     ACT_RDY;
  logic [PE_COL-1:0]     ACT_LST = '0;
  logic [PE_COL*ADW-1:0] ACT_DAT = '0;
  logic [PE_COL*AIW-1:0] ACT_INF = '0;
  logic [NPE-1:0]        WEI_VLD = '1;
  logic [NPE-1:0]        WEI_RDY;
  logic [NPE-1:0]        WEI_LST = '0;
  logic [NPE*WDW-1:0]    WEI_DAT = '0;
  logic [NPE*WIW-1:0]    WEI_INF = '0;
  logic [NPE-1:0]        PE_VLD;
  logic [NPE-1:0]        PE_RDY = '0;
  logic [NPE*EW-1:0]     PE_DAT;

  int tests = 0;
  int fails = 0;
  entry_t exp_q [NPE][$];
  logic [PE_COL-1:0] m_err = '0;

  always #5 clk = ~clk;

  eeg_pea_disp #(
    .PE_ROW(PE_ROW), .PE_COL(PE_COL), .DATA_ACT_DW(ADW), .DATA_WEI_DW(WDW),
    .ACT_IW(AIW), .WEI_IW(WIW), .BUF_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .CFG_MODE(CFG_MODE), .CFG_PE_EN(CFG_PE_EN), .FLUSH(FLUSH),
    .IS_IDLE(IS_IDLE), .ERR_LST(ERR_LST),
    .ACT_VLD(ACT_VLD), .ACT_RDY(ACT_RDY), .ACT_LST(ACT_LST), .ACT_DAT(ACT_DAT), .ACT_INF(ACT_INF),
    .WEI_VLD(WEI_VLD), .WEI_RDY(WEI_RDY), .WEI_LST(WEI_LST), .WEI_DAT(WEI_DAT), .WEI_INF(WEI_INF),
    .PE_VLD(PE_VLD), .PE_RDY(PE_RDY), .PE_DAT(PE_DAT)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit all_empty();
    for (int p = 0; p < NPE; p++) if (exp_q[p].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Monitor: every handshake on a PE port must deliver the oldest expected entry.
  initial begin
    entry_t e;
    forever begin
      @(negedge clk);
      for (int p = 0; p < NPE; p++) begin
        if (PE_VLD[p] === 1'b1 && PE_RDY[p] === 1'b1) begin
          if (exp_q[p].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL pe%0d_pop_empty: got pop expected no data", p);
          end else begin
            e = exp_q[p].pop_front();
            check($sformatf("pe%0d_dat", p), 64'(PE_DAT[p*EW +: EW]), 64'(e));
          end
        end
      end
    end
  end

  // One clock of stimulus plus prediction of the edge that follows.
  task automatic step(input bit rst, input bit flush, input int act_p, input int wei_p,
                      input int rdy_p, input int err_p);
    int nen [PE_COL];
    int nlst [PE_COL];
    int nok [PE_COL];
    bit wok [PE_COL];
    bit lok [PE_COL];
    bit fire [PE_COL];
    bit gfire, glst, any_en, gl, cl, srcv;
    int p, s;
    logic [NPE-1:0]    exp_vld, exp_wrdy;
    logic [PE_COL-1:0] exp_ardy;
    entry_t e;

    @(posedge clk);
    #1;
    rst_n = rst;
    FLUSH = flush;
    gl = ($urandom_range(0, 2) == 0);
    for (int c = 0; c < PE_COL; c++) begin
      ACT_VLD[c] = ($urandom_range(0, 99) < act_p);
      ACT_LST[c] = 1'($urandom_range(0, 1));
      ACT_DAT[c*ADW +: ADW] = ADW'($urandom);
      ACT_INF[c*AIW +: AIW] = AIW'($urandom);
      cl = CFG_MODE ? gl : ($urandom_range(0, 2) == 0);
      for (int r = 0; r < PE_ROW; r++) begin
        p = c * PE_ROW + r;
        WEI_VLD[p] = ($urandom_range(0, 99) < wei_p);
        WEI_LST[p] = cl ^ ($urandom_range(0, 99) < err_p);
        WEI_DAT[p*WDW +: WDW] = WDW'($urandom);
        WEI_INF[p*WIW +: WIW] = WIW'($urandom);
        PE_RDY[p] = (rst || flush) ? 1'b0 : ($urandom_range(0, 99) < rdy_p);
      end
    end
    #2;

    for (int q = 0; q < NPE; q++) exp_vld[q] = (exp_q[q].size() != 0);
    check("pe_vld", 64'(PE_VLD), 64'(exp_vld));
    check("is_idle", 64'(IS_IDLE), 64'(exp_vld == '0));
    check("err_lst", 64'(ERR_LST), 64'(m_err));

    exp_wrdy = '0;
    exp_ardy = '0;
    if (rst || flush) begin
      check("wei_rdy_clr", 64'(WEI_RDY), 64'(exp_wrdy));
      check("act_rdy_clr", 64'(ACT_RDY), 64'(exp_ardy));
      for (int q = 0; q < NPE; q++) exp_q[q].delete();
      m_err = '0;
    end else begin
      any_en = 1'b0;
      gfire = ACT_VLD[0];
      glst = 1'b1;
      for (int c = 0; c < PE_COL; c++) begin
        nen[c] = 0; nlst[c] = 0; nok[c] = 0;
        for (int r = 0; r < PE_ROW; r++) begin
          p = c * PE_ROW + r;
          if (CFG_PE_EN[p]) begin
            nen[c]++;
            if (WEI_LST[p]) nlst[c]++;
            if (WEI_VLD[p] && exp_q[p].size() < DEPTH) nok[c]++;
          end
        end
        wok[c] = (nok[c] == nen[c]);
        lok[c] = (nlst[c] == 0) || (nlst[c] == nen[c]);
        if (nen[c] > 0) begin
          any_en = 1'b1;
          if (!(wok[c] && lok[c])) gfire = 1'b0;
          if (nlst[c] == 0) glst = 1'b0;
        end
      end
      gfire = gfire && any_en;
      for (int c = 0; c < PE_COL; c++) begin
        srcv = CFG_MODE ? ACT_VLD[0] : ACT_VLD[c];
        fire[c] = (nen[c] > 0) && (CFG_MODE ? gfire : (ACT_VLD[c] && wok[c] && lok[c]));
        exp_ardy[c] = CFG_MODE ? (c == 0 && gfire && glst) : (fire[c] && nlst[c] > 0);
        for (int r = 0; r < PE_ROW; r++) exp_wrdy[c*PE_ROW + r] = fire[c] && CFG_PE_EN[c*PE_ROW + r];
        if (srcv && wok[c] && !lok[c]) m_err[c] = 1'b1;
      end
      check("wei_rdy", 64'(WEI_RDY), 64'(exp_wrdy));
      check("act_rdy", 64'(ACT_RDY), 64'(exp_ardy));
      for (int q = 0; q < NPE; q++) begin
        if (exp_wrdy[q]) begin
          s = CFG_MODE ? 0 : q / PE_ROW;
          e = {WEI_LST[q], ACT_LST[s], WEI_INF[q*WIW +: WIW], ACT_INF[s*AIW +: AIW],
               WEI_DAT[q*WDW +: WDW], ACT_DAT[s*ADW +: ADW]};
          exp_q[q].push_back(e);
        end
      end
    end
  endtask

  task automatic drain();
    int n = 0;
    while (!all_empty() && n < 60) begin
      step(0, 0, 0, 0, 100, 0);
      n++;
    end
    if (!all_empty()) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got data after %0d cycles expected empty FIFOs", n);
    end
    check("drain_idle", 64'(IS_IDLE), 64'(all_empty()));
  endtask

  int ph_mode [5] = '{0, 0, 0, 1, 1};
  int ph_rdy [5]  = '{70, 20, 50, 60, 30};

  initial begin
    // Reset with every valid high: nothing may be accepted or presented.
    repeat (3) step(1, 0, 100, 100, 0, 0);
    // First push after release, visible one cycle later.
    step(0, 0, 100, 100, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("first_push_vld", 64'(PE_VLD), 64'({NPE{1'b1}}));

    for (int ph = 0; ph < 5; ph++) begin
      drain();
      step(0, 1, 0, 0, 0, 0);
      CFG_MODE = ph_mode[ph][0];
      case (ph)
        2:       CFG_PE_EN = 16'hBFFF;
        4:       CFG_PE_EN = NPE'($urandom);
        default: CFG_PE_EN = '1;
      endcase
      repeat (300) step(0, 0, 85, 95, ph_rdy[ph], 1);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
